pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16, cycles pll_reset is held high per PLL reset pulse (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 24000, cycles allowed in WAIT_LOCK before a retry (1 ms at 24 MHz; >=1).
REQ-003 Parameter LOCK_STABLE, default 256, consecutive synchronized-lock cycles required before lock is accepted (>=1).
REQ-004 Parameter SYS_RST_HOLD, default 64, cycles sys_reset stays high after lock is accepted (>=1).
REQ-005 Parameter MAX_RETRY, default 3, consecutive lock timeouts that cause FAIL (>=1).
REQ-006 refclk  input  1  free-running 24 MHz reference clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high block reset.
REQ-008 extlock  input  1  PLL lock indication, asynchronous to refclk.
REQ-009 pll_reset  output  1  drives the PLL reset input; high = PLL held in reset.
REQ-010 sys_reset  output  1  active-high reset for the core (CPU, bus) clocked from clk0_out.
REQ-011 locked  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 relock_count  output  8  count of lock losses detected in RUN, saturating at 255.

Function
REQ-014 extlock SHALL pass through a 2-flop synchronizer; lock_s is the second flop; all decisions use lock_s only.
REQ-015 All outputs SHALL be registered and change on the same edge as the state transition that sets them.
REQ-016 States: PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAIL; one shared cycle counter, cleared on every state entry.
REQ-017 PLL_RST: pll_reset=1, sys_reset=1; occupies exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_reset=0, sys_reset=1; lock_s=1 -> STABLE; else after LOCK_TIMEOUT cycles the retry counter increments and -> FAIL if it equals MAX_RETRY, else -> PLL_RST.
REQ-019 STABLE: lock_s=0 on any cycle -> WAIT_LOCK (timeout restarted, no retry increment, no PLL reset); lock_s=1 for LOCK_STABLE consecutive cycles -> HOLD.
REQ-020 HOLD: sys_reset=1 for exactly SYS_RST_HOLD cycles, then -> RUN; lock_s=0 -> PLL_RST.
REQ-021 RUN: sys_reset=0, locked=1, retry counter cleared on entry; lock_s=0 -> PLL_RST and relock_count increments (saturates at 255).
REQ-022 FAIL: pll_reset=0, sys_reset=1, fail=1; terminal until reset, extlock ignored.
REQ-023 Loss of lock in RUN SHALL assert sys_reset no later than 3 refclk edges after extlock falls.
REQ-024 Counters SHALL be sized to hold the largest parameter without wrap; comparisons exact.

Reset
REQ-025 reset=1 at an edge SHALL force, on that edge: state PLL_RST, counter 0, retry 0, synchronizer flops 0, pll_reset=1, sys_reset=1, locked=0, fail=0, relock_count=0.
REQ-026 reset SHALL take priority over every transition, including mid-PLL_RST and FAIL; after release the full PLL_RST_CYCLES pulse is produced.

Verification (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, SYS_RST_HOLD=5, MAX_RETRY=2)
REQ-027 Reset 3 cycles, extlock held 1 -> pll_reset high 4 cycles after release, sys_reset falls and locked rises exactly 18 cycles after release (4+1+8+5), relock_count=0.
REQ-028 extlock held 0 -> two 4-cycle pll_reset pulses separated by 20-cycle waits, fail=1 at cycle 48, pll_reset=0, sys_reset=1 thereafter.
REQ-029 extlock drops 1 cycle during STABLE -> returns to WAIT_LOCK, no pll_reset pulse, sys_reset stays 1, RUN reached 8+5 cycles after lock_s is high again.
REQ-030 extlock falls in RUN -> sys_reset=1 and locked=0 within 3 edges, 4-cycle pll_reset pulse, relock_count=1; relock reaches RUN again.
REQ-031 reset asserted for 1 cycle in RUN with relock_count=5 -> next edge pll_reset=1, sys_reset=1, relock_count=0; normal sequence follows.
REQ-032 260 lock-loss/relock cycles in RUN -> relock_count reaches 255 and holds.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer.
//
// Holds the PLL in reset for a fixed pulse, waits (with timeout and bounded
// retries) for the PLL to report lock, requires lock to be stable for a
// number of cycles, then holds the core in reset a little longer before
// releasing it. Any loss of lock after release restarts the whole sequence
// and is counted.
//
// Ports:
//   refclk        in   free-running reference clock, all logic on rising edge
//   reset         in   synchronous active-high block reset
//   extlock       in   PLL lock indication, asynchronous to refclk
//   pll_reset     out  high = PLL held in reset
//   sys_reset     out  active-high reset for the core clock domain
//   locked        out  high only while running
//   fail          out  high only after exhausting lock retries (terminal)
//   relock_count  out  lock losses seen while running, saturating at 255

module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 24000,
    parameter int unsigned LOCK_STABLE    = 256,
    parameter int unsigned SYS_RST_HOLD   = 64,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic       fail,
    output logic [7:0] relock_count
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE > SYS_RST_HOLD) ? LOCK_STABLE : SYS_RST_HOLD;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StHold,
        StRun,
        StFail
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         relock_q, relock_d;
    logic               lock_meta_q, lock_s_q;
    logic               pll_reset_d, sys_reset_d, locked_d, fail_d;

    // State register, counters, synchronizer and registered outputs.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            lock_meta_q <= extlock;
            lock_s_q    <= lock_meta_q;
            pll_reset   <= pll_reset_d;
            sys_reset   <= sys_reset_d;
            locked      <= locked_d;
            fail        <= fail_d;
        end
    end

    assign relock_count = relock_q;

    // Next-state logic. The counter holds cycles already spent in the
    // current state, so a state lasting N cycles leaves when it reads N-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = StWaitLock;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StStable;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_W'(MAX_RETRY)) ? StFail : StPllRst;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStable: begin
                // A glitch only restarts the lock wait; the PLL is not reset.
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (!lock_s_q) begin
                    state_d = StPllRst;
                end else if (cnt_q == CNT_W'(SYS_RST_HOLD - 1)) begin
                    state_d = StRun;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d  = StPllRst;
                    relock_d = (relock_q == 8'hff) ? relock_q : relock_q + 8'd1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StPllRst;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_comb begin
        pll_reset_d = (state_d == StPllRst);
        sys_reset_d = (state_d != StRun);
        locked_d    = (state_d == StRun);
        fail_d      = (state_d == StFail);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with a phase/elapsed-time model.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int LST = 8;
    localparam int SRH = 5;
    localparam int MR  = 2;

    localparam int P_PRST   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_HOLD   = 3;
    localparam int P_RUN    = 4;
    localparam int P_FAIL   = 5;

    logic       refclk  = 1'b0;
    logic       reset   = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked;
    logic       fail;
    logic [7:0] relock_count;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .LOCK_STABLE   (LST),
        .SYS_RST_HOLD  (SRH),
        .MAX_RETRY     (MR)
    ) dut (
        .refclk      (refclk),
        .reset       (reset),
        .extlock     (extlock),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .fail        (fail),
        .relock_count(relock_count)
    );

    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: current phase, cycles elapsed in it, retries, relocks, and the
    // last two sampled extlock values (hist1 is the synchronized lock).
    int ph      = P_PRST;
    int t       = 0;
    int retries = 0;
    int relocks = 0;
    bit hist0   = 1'b0;
    bit hist1   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ls;
        int nph;
        int done;
        if (reset) begin
            ph      = P_PRST;
            t       = 0;
            retries = 0;
            relocks = 0;
            hist0   = 1'b0;
            hist1   = 1'b0;
            return;
        end
        ls   = hist1;
        nph  = ph;
        done = t + 1;
        case (ph)
            P_PRST:   if (done == PRC) nph = P_WAIT;
            P_WAIT: begin
                if (ls) nph = P_STABLE;
                else if (done == LTO) begin
                    retries++;
                    nph = (retries == MR) ? P_FAIL : P_PRST;
                end
            end
            P_STABLE: begin
                if (!ls) nph = P_WAIT;
                else if (done == LST) nph = P_HOLD;
            end
            P_HOLD: begin
                if (!ls) nph = P_PRST;
                else if (done == SRH) begin
                    nph     = P_RUN;
                    retries = 0;
                end
            end
            P_RUN: begin
                if (!ls) begin
                    nph     = P_PRST;
                    relocks = (relocks < 255) ? relocks + 1 : 255;
                end
            end
            default: nph = ph;
        endcase
        t     = (nph != ph) ? 0 : t + 1;
        ph    = nph;
        hist1 = hist0;
        hist0 = extlock;
    endtask

    // One clock: advance the model on the edge, compare every output just after.
    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        chk("pll_reset", 32'(pll_reset), 32'(ph == P_PRST));
        chk("sys_reset", 32'(sys_reset), 32'(ph != P_RUN));
        chk("locked", 32'(locked), 32'(ph == P_RUN));
        chk("fail", 32'(fail), 32'(ph == P_FAIL));
        chk("relock_count", 32'(relock_count), 32'(relocks));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (!locked && n < bound) begin
            step();
            n++;
        end
        if (!locked) chk("locked_timeout", 32'(locked), 32'd1);
    endtask

    task automatic lose_and_relock();
        int n;
        extlock = 1'b0;
        repeat (3) step();
        extlock = 1'b1;
        wait_locked(60, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int rises;
        int first_fail;
        bit prev;

        // Power-up sequence with lock present throughout.
        extlock = 1'b1;
        do_reset(3);
        chk("reset_pll_reset", 32'(pll_reset), 32'd1);
        n = 0;
        while (pll_reset && n < 10) begin
            step();
            n++;
        end
        chk("pll_pulse_len", n, 4);
        wait_locked(40, m);
        chk("lock_latency", n + m, 18);
        chk("relock_after_boot", 32'(relock_count), 32'd0);

        // No lock at all: two pulses, then terminal failure.
        extlock = 1'b0;
        do_reset(2);
        first_fail = -1;
        rises      = 0;
        prev       = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
            if (fail && first_fail < 0) first_fail = i;
        end
        chk("fail_cycle", first_fail, 48);
        chk("retry_pulses", rises, 1);
        chk("fail_pll_reset", 32'(pll_reset), 32'd0);
        extlock = 1'b1;
        repeat (10) step();
        chk("fail_sticky", 32'(fail), 32'd1);
        chk("fail_sys_reset", 32'(sys_reset), 32'd1);

        // One-cycle lock glitch while checking stability.
        do_reset(1);
        repeat (6) step();
        extlock = 1'b0;
        step();
        extlock = 1'b1;
        n     = 7;
        rises = 0;
        while (!locked && n < 60) begin
            step();
            n++;
            if (pll_reset) rises++;
        end
        chk("glitch_pll_pulses", rises, 0);
        chk("glitch_run_cycle", n, 23);

        // Lock loss while running.
        extlock = 1'b0;
        n = 0;
        while (!sys_reset && n < 6) begin
            step();
            n++;
        end
        chk("loss_detect_edges", n, 3);
        chk("loss_locked", 32'(locked), 32'd0);
        m = pll_reset ? 1 : 0;
        repeat (6) begin
            step();
            if (pll_reset) m++;
        end
        chk("relock_pulse_len", m, 4);
        extlock = 1'b1;
        wait_locked(60, n);
        chk("relock_count_1", 32'(relock_count), 32'd1);

        // Randomized lock behaviour with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) extlock = ~extlock;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset   = 1'b0;
        extlock = 1'b1;

        // Reset in RUN with relock_count = 5.
        do_reset(1);
        wait_locked(40, n);
        repeat (5) lose_and_relock();
        chk("relock_count_5", 32'(relock_count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_sys_reset", 32'(sys_reset), 32'd1);
        chk("rst_relock_count", 32'(relock_count), 32'd0);
        wait_locked(40, n);
        chk("rst_lock_latency", n, 18);

        // Saturation of the relock counter.
        repeat (260) lose_and_relock();
        chk("relock_saturate", 32'(relock_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
